irq_dispatch: RTL
=================

IRQ_DISPATCH -- requirements
Module: irq_dispatch

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter TIMEOUT_CYC, default 255: cycles irq_req may stay unacknowledged before abandonment; legal range 1..255.
REQ-003 Parameter HOLDOFF_CYC, default 2: idle cycles after a clear before inputs are re-sampled; legal range 1..7.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port rst, input, 1: synchronous active-high reset.
REQ-006 Port grp_a, input, 1: group A (highest priority) has an enabled pending request, from the 27-channel priority decoder.
REQ-007 Port grp_b, input, 1: group B has an enabled pending request.
REQ-008 Port grp_c, input, 1: group C (lowest priority) has an enabled pending request.
REQ-009 Port chan, input, 4: winning channel index within the highest active group; legal values 0..8.
REQ-010 Port cpu_ack, input, 1: CPU accepts the presented vector.
REQ-011 Port cpu_eoi, input, 1: one-cycle end-of-interrupt strobe from the CPU.
REQ-012 Port irq_req, output, 1: interrupt request to the CPU.
REQ-013 Port irq_vec, output, 5: vector 0..26, valid while irq_req=1 and held through SERVICE.
REQ-014 Port clr_valid, output, 1: one-cycle strobe telling the upstream pending latch to clear clr_vec.
REQ-015 Port clr_vec, output, 5: vector to clear, valid with clr_valid.
REQ-016 Port err_chan, output, 1: one-cycle strobe when an active group reports chan>8.
REQ-017 Port irq_timeout, output, 1: one-cycle strobe on request abandonment (only with the macro in REQ-036).

Function
REQ-018 Vector computation: grp_a=1 gives chan; else grp_b=1 gives 9+chan; else grp_c=1 gives 18+chan. Result is 5 bits, with no wrap for chan≤8.
REQ-019 A sample is "valid" when any group bit is 1 and chan≤8. An active group with chan>8 SHALL pulse err_chan that cycle and count as "no request".
REQ-020 FSM states: IDLE, QUAL, REQ, SERVICE, CLEAR, HOLD.
REQ-021 IDLE, valid sample: capture the vector into cand and go to QUAL next cycle. Otherwise stay in IDLE.
REQ-022 QUAL, valid sample equal to cand: go to REQ. The qualification latency is 2 cycles from first sample to irq_req=1.
REQ-023 QUAL, valid sample different from cand: recapture cand and stay in QUAL.
REQ-024 QUAL, no valid sample: return to IDLE.
REQ-025 REQ: irq_req=1 and irq_vec=cand. The vector SHALL NOT change while in REQ, even if inputs change.
REQ-026 REQ with cpu_ack=1: go to SERVICE next cycle with irq_req=0, and keep irq_vec.
REQ-027 SERVICE: wait for cpu_eoi=1, then go to CLEAR. cpu_ack is ignored in SERVICE. A cpu_eoi outside SERVICE is ignored.
REQ-028 CLEAR: lasts exactly one cycle, with clr_valid=1 and clr_vec=cand; then go to HOLD.
REQ-029 HOLD: count HOLDOFF_CYC cycles with inputs ignored, then go to IDLE.
REQ-030 cpu_ack and cpu_eoi both high in the same REQ cycle: take only the ack. The eoi is not latched.
REQ-031 Only one request is outstanding at a time, and there is no preemption. A higher-priority arrival is seen only after HOLD.

Reset
REQ-032 rst=1 at any clock edge SHALL force IDLE, including mid-REQ and mid-SERVICE, with no clr_valid issued.
REQ-033 Reset values: irq_req=0, irq_vec=0, clr_valid=0, clr_vec=0, err_chan=0, irq_timeout=0; cand, timeout counter and holdoff counter all 0.
REQ-034 The first sampling is allowed in the first cycle after rst deasserts.

Configuration
REQ-035 Macro IRQ_DISPATCH_TIMEOUT_EN enables the acknowledge timeout.
REQ-036 Defined: the 8-bit counter clears on entry to REQ and increments each REQ cycle without cpu_ack. The cycle it reaches TIMEOUT_CYC, irq_timeout pulses, irq_req drops and the FSM goes to HOLD (no clr_valid). cpu_ack in that same cycle wins and there is no timeout.
REQ-037 Undefined: there is no counter, REQ waits indefinitely, and irq_timeout is tied to 0.

Verification
REQ-038 Group A request: grp_a=1, chan=3 stable 2 cycles → irq_req=1, irq_vec=3; ack → irq_req=0; eoi → clr_valid one cycle, clr_vec=3; HOLD for 2 cycles.
REQ-039 Group C request: grp_c=1, chan=8 → irq_vec=26; change inputs to grp_a=1, chan=0 during REQ → irq_vec stays 26.
REQ-040 Glitch: grp_b chan=2 for 1 cycle, then chan=5 for 2 cycles → single request with irq_vec=14. No request is ever made for vector 11.
REQ-041 Error: grp_a=1, chan=12 → err_chan pulses each cycle, irq_req stays 0.
REQ-042 Timeout, macro on, TIMEOUT_CYC=4: no ack → irq_timeout at the 4th REQ cycle, irq_req=0, no clr_valid. Macro off: irq_req held for 300 cycles.
REQ-043 Reset in SERVICE: rst=1 for 1 cycle → all outputs 0 next cycle, no clr_valid; a request still present is re-dispatched after 2 cycles.

Source files
------------

// File: rtl/irq_dispatch.sv
// Purpose: qualifies the priority-decoder winner, requests the CPU, waits for ack/eoi, then clears the pending latch.
// Latency: irq_req rises 2 cycles after the first valid sample; clr_valid comes 1 cycle after cpu_eoi; HOLDOFF_CYC idle cycles follow.
// Backpressure: one request at a time; inputs are ignored from REQ through HOLD. Macro IRQ_DISPATCH_TIMEOUT_EN adds the ack timeout.
module irq_dispatch #(
    parameter int TIMEOUT_CYC = 255,
    parameter int HOLDOFF_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       grp_a,
    input  logic       grp_b,
    input  logic       grp_c,
    input  logic [3:0] chan,
    input  logic       cpu_ack,
    input  logic       cpu_eoi,
    output logic       irq_req,
    output logic [4:0] irq_vec,
    output logic       clr_valid,
    output logic [4:0] clr_vec,
    output logic       err_chan,
    output logic       irq_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_QUAL,
        S_REQ,
        S_SERVICE,
        S_CLEAR,
        S_HOLD
    } state_t;

    state_t     state;
    logic [4:0] cand;
    logic [2:0] hold_cnt;
    logic       any_grp;
    logic       samp_vld;
    logic [4:0] samp_vec;
    logic       to_fire;

    // Flatten the group/channel pair into a 0..26 vector; chan above 8 is treated as no request.
    always_comb begin
        any_grp  = grp_a | grp_b | grp_c;
        samp_vld = any_grp && (chan <= 4'd8);
        if (grp_a) begin
            samp_vec = {1'b0, chan};
        end else if (grp_b) begin
            samp_vec = 5'd9 + {1'b0, chan};
        end else begin
            samp_vec = 5'd18 + {1'b0, chan};
        end
    end

`ifdef IRQ_DISPATCH_TIMEOUT_EN
    logic [7:0] to_cnt;

    // Abandon the request on the cycle the un-acked REQ count reaches TIMEOUT_CYC; an ack that cycle wins.
    assign to_fire = (state == S_REQ) && !cpu_ack && ((to_cnt + 8'd1) == 8'(TIMEOUT_CYC));

    // Age counter: held at zero outside REQ so it starts fresh on every entry to REQ.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt      <= 8'd0;
            irq_timeout <= 1'b0;
        end else begin
            irq_timeout <= to_fire;
            if (state != S_REQ) begin
                to_cnt <= 8'd0;
            end else if (!cpu_ack) begin
                to_cnt <= to_cnt + 8'd1;
            end
        end
    end
`else
    logic [7:0] unused_timeout_cfg;

    // Without the timeout feature REQ waits for the ack indefinitely.
    assign to_fire            = 1'b0;
    assign irq_timeout        = 1'b0;
    assign unused_timeout_cfg = 8'(TIMEOUT_CYC);
`endif

    // Dispatch FSM with registered outputs; reset abandons any request without clearing upstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cand      <= 5'd0;
            hold_cnt  <= 3'd0;
            irq_req   <= 1'b0;
            irq_vec   <= 5'd0;
            clr_valid <= 1'b0;
            clr_vec   <= 5'd0;
            err_chan  <= 1'b0;
        end else begin
            clr_valid <= 1'b0;
            // Only the sampling states look at the decoder, so only they can flag a bad channel.
            err_chan  <= any_grp && (chan > 4'd8) && ((state == S_IDLE) || (state == S_QUAL));
            case (state)
                S_IDLE: begin
                    if (samp_vld) begin
                        cand  <= samp_vec;
                        state <= S_QUAL;
                    end
                end
                S_QUAL: begin
                    if (!samp_vld) begin
                        state <= S_IDLE;
                    end else if (samp_vec == cand) begin
                        state   <= S_REQ;
                        irq_req <= 1'b1;
                        irq_vec <= cand;
                    end else begin
                        cand <= samp_vec;
                    end
                end
                S_REQ: begin
                    if (cpu_ack) begin
                        state   <= S_SERVICE;
                        irq_req <= 1'b0;
                    end else if (to_fire) begin
                        state    <= S_HOLD;
                        irq_req  <= 1'b0;
                        hold_cnt <= 3'd0;
                    end
                end
                S_SERVICE: begin
                    if (cpu_eoi) begin
                        state     <= S_CLEAR;
                        clr_valid <= 1'b1;
                        clr_vec   <= cand;
                    end
                end
                S_CLEAR: begin
                    state    <= S_HOLD;
                    hold_cnt <= 3'd0;
                end
                S_HOLD: begin
                    if (hold_cnt == 3'(HOLDOFF_CYC - 1)) begin
                        state <= S_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 3'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
